param_icache: RTL

Parametrised direct-mapped instruction cache sitting between the pipeline fetch stage and the memory controller's instruction port. It replaces the pass-through instruction path with a cache that has a configurable set count and multi-word blocks. It serves hits in the same cycle and refills misses word-by-word over the iREN/iwait handshake. Optional hit/miss counters support performance measurement.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/param_icache_if.sv | 28 ++
 rtl/icache_fill_ctrl.sv | 94 +++++++++
 rtl/param_icache.sv | 123 ++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction-side memory hierarchy: word type, cache
// controller states and the fixed byte-offset width of a 32-bit word address.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IC_IDLE = 1'b0,
        IC_FILL = 1'b1
    } icache_state_t;

    localparam int IC_BYTE_OFF_W = 2;

endpackage

// File: rtl/param_icache_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled so the
// cache (slave) and its environment (master: datapath plus memory) share one port.
interface param_icache_if;
    import cpu_types_pkg::*;

    // datapath fetch port
    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;

    // memory controller instruction port
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache_fill_ctrl.sv
// Refill sequencer: latches the missing block, walks its words over the
// iREN/iwait handshake and tells the arrays when to write data and commit tag/valid.
module icache_fill_ctrl
    import cpu_types_pkg::*;
#(
    parameter  int SETS   = 16,
    parameter  int WORDS  = 2,
    localparam int OFF_W  = $clog2(WORDS),
    localparam int IDX_W  = $clog2(SETS),
    localparam int TAG_W  = 32 - IC_BYTE_OFF_W - OFF_W - IDX_W,
    localparam int WCNT_W = (OFF_W > 0) ? OFF_W : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  word_t             i_req_addr,
    input  logic              i_iwait,
    output logic              o_idle,
    output logic              o_iren,
    output word_t             o_iaddr,
    output logic              o_we,
    output logic [IDX_W-1:0]  o_wr_idx,
    output logic [WCNT_W-1:0] o_wr_off,
    output logic              o_commit,
    output logic [TAG_W-1:0]  o_fill_tag
);

    localparam word_t BLK_MASK = ~word_t'(WORDS * 4 - 1);

    icache_state_t     r_state, w_state_nxt;
    logic [WCNT_W-1:0] r_wcnt, w_wcnt_nxt;
    word_t             r_fill_addr, w_fill_addr_nxt;
    logic              w_last;

    // With WORDS=1 the counter is a single constant-zero bit, so every word is the last.
    assign w_last = (r_wcnt == WCNT_W'(WORDS - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the simulator runs processes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IC_IDLE;
            r_wcnt      <= '0;
            r_fill_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_fill_addr <= w_fill_addr_nxt;
        end
    end

    // NOTE: every output of this block is given a default first; a path that
    // left one unassigned would infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_wcnt_nxt      = r_wcnt;
        w_fill_addr_nxt = r_fill_addr;
        o_idle          = 1'b0;
        o_iren          = 1'b0;
        o_iaddr         = '0;
        o_we            = 1'b0;
        o_commit        = 1'b0;

        case (r_state)
            IC_IDLE: begin
                o_idle = 1'b1;
                if (i_start) begin
                    w_state_nxt     = IC_FILL;
                    w_wcnt_nxt      = '0;
                    w_fill_addr_nxt = i_req_addr & BLK_MASK;
                end
            end
            IC_FILL: begin
                o_iren  = 1'b1;
                o_iaddr = r_fill_addr | (word_t'(r_wcnt) << IC_BYTE_OFF_W);
                if (!i_iwait) begin
                    o_we = 1'b1;
                    if (w_last) begin
                        o_commit    = 1'b1;
                        w_state_nxt = IC_IDLE;
                        w_wcnt_nxt  = '0;
                    end else begin
                        w_wcnt_nxt = r_wcnt + WCNT_W'(1);
                    end
                end
            end
        endcase
    end

    assign o_wr_idx   = IDX_W'(r_fill_addr >> (IC_BYTE_OFF_W + OFF_W));
    assign o_fill_tag = TAG_W'(r_fill_addr >> (IC_BYTE_OFF_W + OFF_W + IDX_W));
    assign o_wr_off   = r_wcnt;

endmodule

// File: rtl/param_icache.sv
// Direct-mapped instruction cache with same-cycle hits and word-by-word refill.
// Define ICACHE_STATS_EN to add the hit_count/miss_count performance counters.
module param_icache
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int WORDS = 2
) (
    input  logic  CLK,
    input  logic  nRST,
    param_icache_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output word_t hit_count,
    output word_t miss_count
`endif
);

    localparam int OFF_W  = $clog2(WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - IC_BYTE_OFF_W - OFF_W - IDX_W;
    localparam int WCNT_W = (OFF_W > 0) ? OFF_W : 1;

    word_t             r_data  [SETS][WORDS];
    logic [TAG_W-1:0]  r_tag   [SETS];
    logic [SETS-1:0]   r_valid;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [WCNT_W-1:0] w_off;
    logic              w_idle;
    logic              w_match;
    logic              w_hit;
    logic              w_start;
    logic              w_iren;
    word_t             w_iaddr;
    logic              w_we;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [WCNT_W-1:0] w_wr_off;
    logic              w_commit;
    logic [TAG_W-1:0]  w_fill_tag;

    assign w_idx = IDX_W'(bus.imemaddr >> (IC_BYTE_OFF_W + OFF_W));
    assign w_tag = TAG_W'(bus.imemaddr >> (IC_BYTE_OFF_W + OFF_W + IDX_W));
    assign w_off = (OFF_W == 0) ? '0 : WCNT_W'(bus.imemaddr >> IC_BYTE_OFF_W);

    assign w_match = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_hit   = w_idle && bus.imemREN && w_match;
    assign w_start = w_idle && bus.imemREN && !w_match;

    assign bus.ihit     = w_hit;
    assign bus.imemload = r_data[w_idx][w_off];
    assign bus.iREN     = w_iren;
    assign bus.iaddr    = w_iaddr;

    icache_fill_ctrl #(
        .SETS  (SETS),
        .WORDS (WORDS)
    ) u_fill_ctrl (
        .clk        (CLK),
        .rst_n      (nRST),
        .i_start    (w_start),
        .i_req_addr (bus.imemaddr),
        .i_iwait    (bus.iwait),
        .o_idle     (w_idle),
        .o_iren     (w_iren),
        .o_iaddr    (w_iaddr),
        .o_we       (w_we),
        .o_wr_idx   (w_wr_idx),
        .o_wr_off   (w_wr_off),
        .o_commit   (w_commit),
        .o_fill_tag (w_fill_tag)
    );

    // NOTE: the arrays are flops, not SRAM, so they can be cleared by reset;
    // that keeps imemload at zero after reset instead of leaking stale words.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_tag[s] <= '0;
                for (int w = 0; w < WORDS; w++) begin
                    r_data[s][w] <= '0;
                end
            end
        end else begin
            if (w_we) begin
                r_data[w_wr_idx][w_wr_off] <= bus.iload;
            end
            // Invalidate on fill start so a partially refilled block can never hit.
            if (w_start) begin
                r_valid[w_idx] <= 1'b0;
            end
            if (w_commit) begin
                r_valid[w_wr_idx] <= 1'b1;
                r_tag[w_wr_idx]   <= w_fill_tag;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    word_t r_hit_count;
    word_t r_miss_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_start) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
